// File: rtl/input_conditioner.sv
// Per-channel synchroniser, symmetric tick-based debouncer, press/release pulses
// and optional hold-to-repeat for WIDTH mechanical inputs.
module input_conditioner #(
  parameter int WIDTH            = 7,
  parameter int SYNC_STAGES      = 2,
  parameter int SAMPLE_COUNT_MAX = 38000,
  parameter int PULSE_COUNT_MAX  = 150,
  parameter int HOLD_TICKS       = 400,
  parameter int REPEAT_TICKS     = 100
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] repeat_en,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  // release/repeat are reserved words, so the pulses are named rel/rpt
  output logic [WIDTH-1:0] rel,
  output logic [WIDTH-1:0] rpt
);

  localparam int TW   = (SAMPLE_COUNT_MAX > 1) ? $clog2(SAMPLE_COUNT_MAX) : 1;
  localparam int CW   = $clog2(PULSE_COUNT_MAX + 1);
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p;
  logic [WIDTH-1:0]                  s;
  logic [TW-1:0]                     tick_cnt;
  logic                              tick;
  logic [CW-1:0]                     cnt [WIDTH];
  logic [HW-1:0]                     hc [WIDTH];
  logic [WIDTH-1:0]                  hc_rep;
  logic [WIDTH-1:0]                  flip;
  logic [WIDTH-1:0]                  rep_due;

  // Stage 0: metastability synchroniser
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync_p[SYNC_STAGES-1];

  // Stage 1: shared sample tick
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TW'(SAMPLE_COUNT_MAX - 1));

  always_comb begin
    flip    = '0;
    rep_due = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i]    = tick && (s[i] != level[i]) && (cnt[i] == CW'(PULSE_COUNT_MAX - 1));
      rep_due[i] = tick && level[i] && repeat_en[i] &&
                   ((hc[i] + HW'(1)) == (hc_rep[i] ? HW'(REPEAT_TICKS) : HW'(HOLD_TICKS)));
    end
  end

  // Stage 2: debounced level, edge pulses and auto-repeat
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
        hc[i]  <= '0;
      end
      hc_rep <= '0;
      level  <= '0;
      press  <= '0;
      rel    <= '0;
      rpt    <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (tick) begin
          if ((s[i] == level[i]) || flip[i]) begin
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end

        press[i] <= flip[i] & ~level[i];
        rel[i]   <= flip[i] & level[i];
        if (flip[i]) begin
          level[i] <= ~level[i];
        end

        // A release landing on a due repeat wins: the hold state is simply dropped.
        if (!level[i] || !repeat_en[i] || flip[i]) begin
          hc[i]     <= '0;
          hc_rep[i] <= 1'b0;
          rpt[i]    <= 1'b0;
        end else if (rep_due[i]) begin
          hc[i]     <= '0;
          hc_rep[i] <= 1'b1;
          rpt[i]    <= 1'b1;
        end else begin
          rpt[i] <= 1'b0;
          if (tick) begin
            hc[i] <= hc[i] + HW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: sync/debounce latency, glitch rejection,
// auto-repeat timing, simultaneous channels, async reset and bounce handling.
module tb_input_conditioner;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic [W-1:0] in = '0;
  logic [W-1:0] repeat_en = '0;
  logic [W-1:0] level, press, rel, rpt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_press [W];
  int n_rel [W];
  int n_rpt [W];
  int t_press [W];
  int t_rel [W];
  int t_rpt2 [$];
  int n_overlap = 0;
  int w;

  input_conditioner #(
    .WIDTH(W), .SYNC_STAGES(2), .SAMPLE_COUNT_MAX(4),
    .PULSE_COUNT_MAX(3), .HOLD_TICKS(5), .REPEAT_TICKS(2)
  ) dut (
    .clk(clk), .rst_b(rst_b), .in(in), .repeat_en(repeat_en),
    .level(level), .press(press), .rel(rel), .rpt(rpt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    cyc++;
    for (int i = 0; i < W; i++) begin
      if (press[i]) begin n_press[i]++; t_press[i] = cyc; end
      if (rel[i])   begin n_rel[i]++;   t_rel[i]   = cyc; end
      if (rpt[i])   n_rpt[i]++;
    end
    if (rpt[2]) t_rpt2.push_back(cyc);
    if ((rpt & (press | rel)) != '0) n_overlap++;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
      sample();
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_rpt[i] = 0; t_press[i] = 0; t_rel[i] = 0;
    end
    t_rpt2.delete();
  endtask

  task automatic wait_level(input int ch, input logic val, input int limit, output int waited);
    waited = 0;
    while ((level[ch] !== val) && (waited < limit)) begin
      cycles(1);
      waited++;
    end
  endtask

  initial begin
    clear_counts();
    cycles(3);
    chk("rst_level", 32'(level), 0);
    chk("rst_pulses", 32'({press, rel, rpt}), 0);
    rst_b = 1'b1;
    cycles(2);
    chk("post_rst_level", 32'(level), 0);

    // 1: clean press and release on channel 0, no repeat enabled
    in[0] = 1'b1;
    wait_level(0, 1'b1, 20, w);
    chk("t1_rise_latency_ok", 32'((w >= 3) && (w <= 14)), 1);
    chk("t1_press_same_cycle", 32'(press), 4'b0001);
    chk("t1_level", 32'(level), 4'b0001);
    cycles(1);
    chk("t1_press_width", 32'(press), 0);
    cycles(20);
    chk("t1_press_count", n_press[0], 1);
    chk("t1_no_repeat", n_rpt[0] + n_rpt[1] + n_rpt[2] + n_rpt[3], 0);
    chk("t1_no_release", n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3], 0);
    in[0] = 1'b0;
    wait_level(0, 1'b0, 20, w);
    chk("t1_fall_latency_ok", 32'((w >= 3) && (w <= 14)), 1);
    chk("t1_release_pulse", 32'(rel), 4'b0001);
    cycles(1);
    chk("t1_release_width", 32'(rel), 0);

    // 2: two-tick glitch on channel 1 is rejected
    clear_counts();
    in[1] = 1'b1;
    cycles(8);
    in[1] = 1'b0;
    cycles(30);
    chk("t2_glitch_press", n_press[1], 0);
    chk("t2_glitch_release", n_rel[1], 0);
    chk("t2_glitch_level", 32'(level), 0);

    // 3: auto-repeat on channel 2; release lands on a due repeat and suppresses it
    clear_counts();
    repeat_en = 4'b0100;
    in[2] = 1'b1;
    wait_level(2, 1'b1, 20, w);
    chk("t3_press", 32'(press), 4'b0100);
    cycles(40);
    in[2] = 1'b0;
    wait_level(2, 1'b0, 20, w);
    chk("t3_release_latency", w, 12);
    chk("t3_release_offset", t_rel[2] - t_press[2], 52);
    chk("t3_repeat_count", n_rpt[2], 4);
    for (int k = 0; (k < t_rpt2.size()) && (k < 4); k++) begin
      chk($sformatf("t3_repeat_time_%0d", k), t_rpt2[k] - t_press[2], 20 + 8 * k);
    end
    cycles(20);
    chk("t3_repeat_after_release", n_rpt[2], 4);
    chk("t3_release_count", n_rel[2], 1);
    repeat_en = '0;

    // 4: simultaneous press on channels 0 and 3
    clear_counts();
    in = 4'b1001;
    wait_level(0, 1'b1, 20, w);
    chk("t4_press_both", 32'(press), 4'b1001);
    chk("t4_level_both", 32'(level), 4'b1001);
    cycles(1);
    chk("t4_press_width", 32'(press), 0);

    // 5: asynchronous reset while channel 2 is mid-hold
    clear_counts();
    repeat_en[2] = 1'b1;
    in[2] = 1'b1;
    wait_level(2, 1'b1, 20, w);
    cycles(24);
    chk("t5_repeat_before_rst", n_rpt[2], 1);
    chk("t5_level_before_rst", 32'(level), 4'b1101);
    #1;
    rst_b = 1'b0;
    #1;
    chk("t5_async_clear", 32'({level, press, rel, rpt}), 0);
    clear_counts();
    cycles(3);
    rst_b = 1'b1;
    clear_counts();
    wait_level(2, 1'b1, 20, w);
    chk("t5_redebounce_latency", w, 12);
    chk("t5_press_refire", 32'(press), 4'b1101);
    chk("t5_no_exit_pulses", n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3] +
                             n_rpt[0] + n_rpt[1] + n_rpt[2] + n_rpt[3], 0);
    // repeat_en dropped mid-hold, then restored: hold delay restarts
    cycles(12);
    repeat_en[2] = 1'b0;
    cycles(20);
    chk("t5_disabled_no_repeat", n_rpt[2], 0);
    repeat_en[2] = 1'b1;
    cycles(21);
    chk("t5_reenable_repeat", n_rpt[2], 1);
    if (t_rpt2.size() > 0) chk("t5_reenable_time", t_rpt2[0] - t_press[2], 52);
    else chk("t5_reenable_time", -1, 52);
    in = '0;
    repeat_en = '0;
    cycles(20);
    chk("t5_all_released", 32'(level), 0);

    // 6: bouncy release on channel 1
    clear_counts();
    in[1] = 1'b1;
    wait_level(1, 1'b1, 20, w);
    chk("t6_press_count", n_press[1], 1);
    for (int k = 0; k < 13; k++) begin
      in[1] = ~in[1];
      cycles(3);
    end
    chk("t6_level_held_in_bounce", 32'(level[1]), 1);
    chk("t6_no_release_in_bounce", n_rel[1], 0);
    in[1] = 1'b0;
    cycles(20);
    chk("t6_release_count", n_rel[1], 1);
    chk("t6_press_total", n_press[1], 1);
    chk("t6_level_final", 32'(level), 0);

    chk("no_repeat_overlap", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
